ejtag_scan_gen2: RTL and testbench
==================================

// Module: ejtag_scan_gen2
// PURPOSE
//  Parametrised EJTAG scan-chain block: next generation of the EJTAG data/address/control scan registers.
//  Sits between the TAP controller (IR and state decodes) and the EJTAG probe/DMA logic.
//  Data, address and control widths are generic. A shift-length checker suppresses update strobes
//  when the probe shifted a wrong bit count, and reports the error. Update and PC-trace outputs are registered.
// PARAMETERS
//  DW    32  data/implementation chain width (>=8)
//  AW    32  address chain width (>=8)
//  CW    32  control chain width (>=8)
//  CNTW  8   shift-counter width; 2**CNTW-1 > DW+AW+CW is required
// PORTS
//  JTAG_CLOCK      in   1     TCK-domain clock, rising edge
//  RESET_JR        in   1     async reset, active high
//  JTAG_IR         in   5     current instruction
//  JTAG_CAPTURE    in   1     TAP Capture-DR state
//  JTAG_SHIFT      in   1     TAP Shift-DR state
//  JTAG_UPDATE     in   1     TAP Update-DR state
//  JTAG_RUNTEST    in   1     TAP Run-Test/Idle state
//  JTAG_ESCANIN    in   1     serial in (TDI)
//  MDATA_IN        in   DW    capture value, data chain
//  MADDR_IN        in   AW    capture value, address chain
//  CTL_IN          in   CW    capture value, control chain
//  IMPL_IN         in   DW    capture value, implementation chain
//  JTAG_ESCANOUT   out  1     serial out (TDO)
//  EJSN_DATA       out  DW    data chain contents
//  EJSN_ADDR       out  AW    address chain contents
//  EJSN_CTL        out  CW    control chain contents
//  EJSN_UPDATEDATA out  1     1-cycle strobe, data valid
//  EJSN_UPDATEADDR out  1     1-cycle strobe, address valid
//  EJSN_UPDATECTL  out  1     1-cycle strobe, control valid
//  EJSN_SHIFTERR   out  1     sticky wrong-length flag
//  EJSN_SHIFTCNT   out  CNTW  bits shifted since last capture
//  EJSN_PCTRACEON  out  1     PC trace enable
// BEHAVIOUR
//  IR codes: IMPL=5'h03, ADDR=5'h08, DATA=5'h09, CTRL=5'h0A, ALL=5'h0B, PCTRACE=5'h10.
//    Any other code selects no chain.
//  Chain length L: IMPL/DATA=DW, ADDR=AW, CTRL=CW, ALL=DW+AW+CW.
//  Reset values: all registers, outputs and counters are 0 asynchronously on RESET_JR.
//    Reset mid-shift discards the partial shift and clears the sticky error.
//  Priority when TAP decodes overlap: CAPTURE > SHIFT > UPDATE. Lower-priority actions are ignored that cycle.
//  CAPTURE (registered at the next edge):
//    - Loads the selected chain: DATA<-MDATA_IN, ADDR<-MADDR_IN, CTRL<-CTL_IN, IMPL loads the data reg <-IMPL_IN.
//    - ALL loads all three chains.
//    - Clears SHIFTCNT and SHIFTERR. Unselected codes leave all state untouched.
//  SHIFT, per cycle:
//    - The selected chain shifts right; ESCANIN enters the MSB.
//    - ALL order is {ADDR,DATA,CTL}: ESCANIN enters ADDR MSB; CTL LSB exits.
//    - SHIFTCNT increments and saturates at 2**CNTW-1 (no wrap). SHIFTCNT is unchanged for unselected codes.
//  ESCANOUT is combinational from flops: LSB of the selected chain (CTL LSB for ALL) while JTAG_SHIFT=1, else 0.
//  UPDATE, with a selected chain other than IMPL:
//    - If SHIFTCNT==L, the matching strobes go high on the next edge for exactly 1 cycle. ALL asserts all three.
//    - If SHIFTCNT!=L, no strobe fires and SHIFTERR sets on the next edge.
//    - UPDATE on IMPL, or on an unselected code, has no effect.
//    - UPDATE held 2+ cycles produces one strobe only; a rising-edge detect is required.
//    - SHIFTERR holds until the next CAPTURE or reset. Chain contents are never altered by UPDATE.
//  PCTRACEON is registered: PCTRACEON <= JTAG_RUNTEST && (JTAG_IR==PCTRACE), so it has 1-cycle latency.
// TESTING
//  T1: reset, then ADDR with MADDR_IN=32'hDEADBEEF, capture, 32 shifts of 0
//      -> ESCANOUT serialises BEEF.. LSB-first; EJSN_ADDR=0; one UPDATEADDR pulse; SHIFTERR=0.
//  T2: DATA, capture, 31 shifts, update -> no UPDATEDATA; SHIFTERR=1; next CAPTURE clears it.
//  T3: ALL, MDATA_IN=1, MADDR_IN=2, CTL_IN=3, 96 shifts of TDI=1 then update
//      -> all three strobes in the same cycle; EJSN_* all-ones; TDO sequence is CTL,DATA,ADDR.
//  T4: IMPL with IMPL_IN=32'h0081_0200, capture, 32 shifts -> TDO stream matches; update gives no strobe, no error.
//  T5: 300 shifts with CNTW=8 -> SHIFTCNT saturates at 255; update sets SHIFTERR.
//  T6: RESET_JR pulsed mid-shift (count 10) -> all outputs 0 immediately; PCTRACEON follows RUNTEST&&IR=5'h10 one cycle later.

Source files
------------

// File: rtl/ejtag_scan_gen2.sv
// ejtag_scan_gen2: EJTAG data/address/control scan chains with shift-length checking and PC-trace enable
// Ports:
//   JTAG_CLOCK/RESET_JR             TCK clock, async active-high reset
//   JTAG_IR, JTAG_CAPTURE/SHIFT/UPDATE/RUNTEST  TAP instruction and state decodes
//   JTAG_ESCANIN/JTAG_ESCANOUT      serial in (TDI) / serial out (TDO)
//   MDATA_IN, MADDR_IN, CTL_IN, IMPL_IN          capture values
//   EJSN_DATA/ADDR/CTL              chain contents
//   EJSN_UPDATEDATA/ADDR/CTL        one-cycle update strobes
//   EJSN_SHIFTERR, EJSN_SHIFTCNT    sticky wrong-length flag, shift counter
//   EJSN_PCTRACEON                  registered PC trace enable
module ejtag_scan_gen2 #(
  parameter int DW   = 32,
  parameter int AW   = 32,
  parameter int CW   = 32,
  parameter int CNTW = 8
) (
  input  logic            JTAG_CLOCK,
  input  logic            RESET_JR,
  input  logic [4:0]      JTAG_IR,
  input  logic            JTAG_CAPTURE,
  input  logic            JTAG_SHIFT,
  input  logic            JTAG_UPDATE,
  input  logic            JTAG_RUNTEST,
  input  logic            JTAG_ESCANIN,
  input  logic [DW-1:0]   MDATA_IN,
  input  logic [AW-1:0]   MADDR_IN,
  input  logic [CW-1:0]   CTL_IN,
  input  logic [DW-1:0]   IMPL_IN,
  output logic            JTAG_ESCANOUT,
  output logic [DW-1:0]   EJSN_DATA,
  output logic [AW-1:0]   EJSN_ADDR,
  output logic [CW-1:0]   EJSN_CTL,
  output logic            EJSN_UPDATEDATA,
  output logic            EJSN_UPDATEADDR,
  output logic            EJSN_UPDATECTL,
  output logic            EJSN_SHIFTERR,
  output logic [CNTW-1:0] EJSN_SHIFTCNT,
  output logic            EJSN_PCTRACEON
);
  localparam int TW = AW + DW + CW;
  localparam logic [CNTW-1:0] LEN_D   = CNTW'(DW);
  localparam logic [CNTW-1:0] LEN_A   = CNTW'(AW);
  localparam logic [CNTW-1:0] LEN_C   = CNTW'(CW);
  localparam logic [CNTW-1:0] LEN_ALL = CNTW'(TW);

  logic [DW-1:0]   data_q, data_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [CW-1:0]   ctl_q, ctl_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;
  logic            upd_q;
  logic [2:0]      strb_q, strb_d;
  logic            pc_q;

  logic s_impl, s_addr, s_data, s_ctrl, s_all, sel;
  logic cap, sh, upd, len_ok;
  logic [CNTW-1:0] len;
  logic [TW-1:0]   all_sh;

  assign s_impl = JTAG_IR == 5'h03;
  assign s_addr = JTAG_IR == 5'h08;
  assign s_data = JTAG_IR == 5'h09;
  assign s_ctrl = JTAG_IR == 5'h0A;
  assign s_all  = JTAG_IR == 5'h0B;
  assign sel    = s_impl | s_addr | s_data | s_ctrl | s_all;
  assign len    = s_addr ? LEN_A : s_ctrl ? LEN_C : s_all ? LEN_ALL : LEN_D;
  assign len_ok = cnt_q == len;

  // CAPTURE beats SHIFT beats UPDATE; UPDATE acts only on its rising edge
  assign cap = JTAG_CAPTURE & sel;
  assign sh  = ~JTAG_CAPTURE & JTAG_SHIFT & sel;
  assign upd = ~JTAG_CAPTURE & ~JTAG_SHIFT & JTAG_UPDATE & ~upd_q & sel & ~s_impl;

  // ALL mode is one long chain: TDI -> ADDR -> DATA -> CTL -> TDO
  assign all_sh = {JTAG_ESCANIN, addr_q, data_q, ctl_q[CW-1:1]};

  always_comb begin
    data_d = data_q;
    addr_d = addr_q;
    ctl_d  = ctl_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    if (cap) begin
      data_d = s_impl ? IMPL_IN : (s_data | s_all) ? MDATA_IN : data_q;
      addr_d = (s_addr | s_all) ? MADDR_IN : addr_q;
      ctl_d  = (s_ctrl | s_all) ? CTL_IN : ctl_q;
      cnt_d  = '0;
      err_d  = 1'b0;
    end else if (sh) begin
      if (s_all) {addr_d, data_d, ctl_d} = all_sh;
      if (s_data | s_impl) data_d = {JTAG_ESCANIN, data_q[DW-1:1]};
      if (s_addr) addr_d = {JTAG_ESCANIN, addr_q[AW-1:1]};
      if (s_ctrl) ctl_d = {JTAG_ESCANIN, ctl_q[CW-1:1]};
      cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
    end else if (upd) begin
      err_d = err_q | ~len_ok;
    end
  end

  assign strb_d = (upd & len_ok) ? {s_data | s_all, s_addr | s_all, s_ctrl | s_all} : 3'b000;

  always_ff @(posedge JTAG_CLOCK or posedge RESET_JR) begin
    if (RESET_JR) begin
      data_q <= '0;
      addr_q <= '0;
      ctl_q  <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
      upd_q  <= 1'b0;
      strb_q <= 3'b000;
      pc_q   <= 1'b0;
    end else begin
      data_q <= data_d;
      addr_q <= addr_d;
      ctl_q  <= ctl_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      upd_q  <= JTAG_UPDATE;
      strb_q <= strb_d;
      pc_q   <= JTAG_RUNTEST & (JTAG_IR == 5'h10);
    end
  end

  assign JTAG_ESCANOUT = JTAG_SHIFT & (((s_all | s_ctrl) & ctl_q[0]) | (s_addr & addr_q[0]) |
                                       ((s_data | s_impl) & data_q[0]));
  assign EJSN_DATA       = data_q;
  assign EJSN_ADDR       = addr_q;
  assign EJSN_CTL        = ctl_q;
  assign EJSN_UPDATEDATA = strb_q[2];
  assign EJSN_UPDATEADDR = strb_q[1];
  assign EJSN_UPDATECTL  = strb_q[0];
  assign EJSN_SHIFTERR   = err_q;
  assign EJSN_SHIFTCNT   = cnt_q;
  assign EJSN_PCTRACEON  = pc_q;
endmodule

// File: tb/tb_ejtag_scan_gen2.sv
// tb_ejtag_scan_gen2: directed, table-driven and randomized checks of ejtag_scan_gen2 against a behavioural model
module tb_ejtag_scan_gen2;
  logic clk = 0, rst = 0;
  logic [4:0] ir = 0;
  logic cap = 0, sh = 0, upd = 0, rt = 0, tdi = 0;
  logic [31:0] mdata = 0, maddr = 0, ctlin = 0, impl = 0;
  logic tdo, ud, ua, uc, serr, pc;
  logic [31:0] d_o, a_o, c_o;
  logic [7:0] cnt;
  int errors = 0, checks = 0;

  logic [31:0] m_data, m_addr, m_ctl;
  int m_cnt;
  logic m_err, m_prev, m_pc;
  logic [2:0] m_str;

  typedef struct {
    logic [4:0] ir;
    logic       rt;
    int         n;
    logic [2:0] mask;
    logic       pc;
  } vec_t;
  vec_t vt[8];
  logic [4:0] irs[8];
  logic [95:0] got, e96;
  logic [31:0] e32;

  ejtag_scan_gen2 dut (
    .JTAG_CLOCK(clk), .RESET_JR(rst), .JTAG_IR(ir), .JTAG_CAPTURE(cap), .JTAG_SHIFT(sh),
    .JTAG_UPDATE(upd), .JTAG_RUNTEST(rt), .JTAG_ESCANIN(tdi), .MDATA_IN(mdata), .MADDR_IN(maddr),
    .CTL_IN(ctlin), .IMPL_IN(impl), .JTAG_ESCANOUT(tdo), .EJSN_DATA(d_o), .EJSN_ADDR(a_o),
    .EJSN_CTL(c_o), .EJSN_UPDATEDATA(ud), .EJSN_UPDATEADDR(ua), .EJSN_UPDATECTL(uc),
    .EJSN_SHIFTERR(serr), .EJSN_SHIFTCNT(cnt), .EJSN_PCTRACEON(pc)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [95:0] act, logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int chain_len(logic [4:0] c);
    case (c)
      5'h03, 5'h08, 5'h09, 5'h0A: return 32;
      5'h0B: return 96;
      default: return 0;
    endcase
  endfunction

  function automatic logic m_tdo();
    if (!sh) return 1'b0;
    case (ir)
      5'h03, 5'h09: return m_data[0];
      5'h08: return m_addr[0];
      5'h0A, 5'h0B: return m_ctl[0];
      default: return 1'b0;
    endcase
  endfunction

  // next model state from the current inputs, following the priority and update rules
  task automatic m_step();
    logic [95:0] big;
    int L;
    L = chain_len(ir);
    m_str = 3'b000;
    if (cap && L > 0) begin
      if (ir == 5'h03) m_data = impl;
      if (ir == 5'h09 || ir == 5'h0B) m_data = mdata;
      if (ir == 5'h08 || ir == 5'h0B) m_addr = maddr;
      if (ir == 5'h0A || ir == 5'h0B) m_ctl = ctlin;
      m_cnt = 0;
      m_err = 0;
    end else if (sh && L > 0) begin
      if (ir == 5'h0B) begin
        big = {m_addr, m_data, m_ctl} >> 1;
        big[95] = tdi;
        {m_addr, m_data, m_ctl} = big;
      end else if (ir == 5'h08) m_addr = {tdi, m_addr[31:1]};
      else if (ir == 5'h0A) m_ctl = {tdi, m_ctl[31:1]};
      else m_data = {tdi, m_data[31:1]};
      m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
    end else if (upd && !m_prev && L > 0 && ir != 5'h03) begin
      if (m_cnt == L) m_str = {ir == 5'h09 || ir == 5'h0B, ir == 5'h08 || ir == 5'h0B, ir == 5'h0A || ir == 5'h0B};
      else m_err = 1;
    end
    m_prev = upd;
    m_pc = rt && (ir == 5'h10);
  endtask

  task automatic check_model();
    chk("data", 96'(d_o), 96'(m_data));
    chk("addr", 96'(a_o), 96'(m_addr));
    chk("ctl", 96'(c_o), 96'(m_ctl));
    chk("strobes", 96'({ud, ua, uc}), 96'(m_str));
    chk("shifterr", 96'(serr), 96'(m_err));
    chk("shiftcnt", 96'(cnt), 96'(m_cnt));
    chk("pctraceon", 96'(pc), 96'(m_pc));
    chk("escanout", 96'(tdo), 96'(m_tdo()));
  endtask

  task automatic tick();
    m_step();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    m_data = 0; m_addr = 0; m_ctl = 0; m_cnt = 0;
    m_err = 0; m_prev = 0; m_pc = 0; m_str = 0;
    check_model();
    #1 rst = 0;
  endtask

  // capture the chain, then shift n bits recording TDO (tmode 0/1 fixed TDI, 2 random)
  task automatic run_seq(logic [4:0] c, int n, int tmode, output logic [95:0] g);
    g = '0;
    ir = c;
    cap = 1;
    tick();
    cap = 0;
    sh = 1;
    for (int i = 0; i < n; i++) begin
      tdi = (tmode == 2) ? 1'($urandom) : (tmode == 1);
      #1;
      if (i < 96) g[i] = tdo;
      tick();
    end
    sh = 0;
  endtask

  initial begin
    vt[0] = '{5'h03, 1'b0, 32, 3'b000, 1'b0};
    vt[1] = '{5'h08, 1'b1, 32, 3'b010, 1'b0};
    vt[2] = '{5'h09, 1'b0, 32, 3'b100, 1'b0};
    vt[3] = '{5'h0A, 1'b0, 32, 3'b001, 1'b0};
    vt[4] = '{5'h0B, 1'b0, 96, 3'b111, 1'b0};
    vt[5] = '{5'h10, 1'b1, 0, 3'b000, 1'b1};
    vt[6] = '{5'h10, 1'b0, 0, 3'b000, 1'b0};
    vt[7] = '{5'h00, 1'b1, 0, 3'b000, 1'b0};
    irs = '{5'h03, 5'h08, 5'h09, 5'h0A, 5'h0B, 5'h10, 5'h00, 5'h1F};
    do_reset();

    // T1: address chain, exact length, update held for several cycles
    maddr = 32'hDEADBEEF;
    e32 = 32'hDEADBEEF;
    run_seq(5'h08, 32, 0, got);
    chk("t1_tdo_stream", 96'(got[31:0]), 96'(e32));
    chk("t1_addr_zero", 96'(a_o), 96'd0);
    upd = 1;
    tick();
    chk("t1_updaddr", 96'({ud, ua, uc}), 96'(3'b010));
    tick();
    chk("t1_single_pulse", 96'({ud, ua, uc}), 96'd0);
    upd = 0;
    tick();
    chk("t1_no_err", 96'(serr), 96'd0);

    // T2: one bit short -> error, cleared by the next capture
    run_seq(5'h09, 31, 2, got);
    upd = 1;
    tick();
    chk("t2_no_strobe", 96'({ud, ua, uc}), 96'd0);
    chk("t2_err_set", 96'(serr), 96'd1);
    tick();
    upd = 0;
    tick();
    chk("t2_err_sticky", 96'(serr), 96'd1);
    cap = 1;
    tick();
    cap = 0;
    chk("t2_err_cleared", 96'(serr), 96'd0);

    // T3: all chains in one scan
    mdata = 1; maddr = 2; ctlin = 3;
    run_seq(5'h0B, 96, 1, got);
    e96 = {32'd2, 32'd1, 32'd3};
    chk("t3_tdo_stream", got, e96);
    chk("t3_all_ones", 96'({a_o, d_o, c_o}), {96{1'b1}});
    upd = 1;
    tick();
    chk("t3_all_strobes", 96'({ud, ua, uc}), 96'(3'b111));
    upd = 0;
    tick();

    // T4: implementation chain never strobes
    impl = 32'h0081_0200;
    e32 = 32'h0081_0200;
    run_seq(5'h03, 32, 0, got);
    chk("t4_tdo_stream", 96'(got[31:0]), 96'(e32));
    upd = 1;
    tick();
    chk("t4_no_strobe", 96'({ud, ua, uc}), 96'd0);
    chk("t4_no_err", 96'(serr), 96'd0);
    upd = 0;
    tick();

    // T5: counter saturation
    run_seq(5'h08, 300, 2, got);
    chk("t5_cnt_sat", 96'(cnt), 96'd255);
    upd = 1;
    tick();
    chk("t5_err", 96'(serr), 96'd1);
    upd = 0;
    tick();

    // T6: reset mid-shift, then PC trace latency
    run_seq(5'h09, 10, 2, got);
    chk("t6_cnt10", 96'(cnt), 96'd10);
    sh = 1;
    do_reset();
    chk("t6_rst_outputs", 96'({d_o, cnt, serr, tdo}), 96'd0);
    sh = 0;
    ir = 5'h10;
    rt = 1;
    #1;
    chk("t6_pc_latency", 96'(pc), 96'd0);
    tick();
    chk("t6_pc_on", 96'(pc), 96'd1);
    rt = 0;
    tick();
    chk("t6_pc_off", 96'(pc), 96'd0);

    // table: per-instruction strobe mask and PC trace
    do_reset();
    for (int k = 0; k < 8; k++) begin
      rt = vt[k].rt;
      run_seq(vt[k].ir, vt[k].n, 2, got);
      upd = 1;
      tick();
      chk($sformatf("tbl%0d_strobes", k), 96'({ud, ua, uc}), 96'(vt[k].mask));
      chk($sformatf("tbl%0d_err", k), 96'(serr), 96'd0);
      chk($sformatf("tbl%0d_pc", k), 96'(pc), 96'(vt[k].pc));
      upd = 0;
      tick();
      chk($sformatf("tbl%0d_strobe_drop", k), 96'({ud, ua, uc}), 96'd0);
    end

    // random transactions with lengths around the exact chain length
    for (int t = 0; t < 40; t++) begin
      int L, n, off;
      ir = irs[$urandom_range(0, 7)];
      mdata = $urandom; maddr = $urandom; ctlin = $urandom; impl = $urandom;
      rt = 1'($urandom);
      L = chain_len(ir);
      off = int'($urandom_range(0, 3));
      n = (L == 0) ? int'($urandom_range(0, 5)) : L + ((off == 0) ? -1 : (off == 3) ? 1 : 0);
      run_seq(ir, n, 2, got);
      upd = 1;
      repeat ($urandom_range(1, 3)) tick();
      upd = 0;
      tick();
    end

    // random free-running decodes, including overlaps
    for (int t = 0; t < 300; t++) begin
      ir = irs[$urandom_range(0, 7)];
      cap = ($urandom_range(0, 9) == 0);
      sh = 1'($urandom);
      upd = ($urandom_range(0, 3) == 0);
      rt = 1'($urandom);
      tdi = 1'($urandom);
      mdata = $urandom; maddr = $urandom; ctlin = $urandom; impl = $urandom;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
